// File: rtl/pwm_multi_ch.sv
// Multi-channel edge-aligned PWM generator with one shared period counter.
// Period and duty are double-buffered so that changes only take effect at a period boundary.
module pwm_multi_ch #(
  parameter int CH      = 4,
  parameter int CW      = 16,
  parameter int DEF_PER = 4999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CW-1:0]    per_in,
  input  logic [CH*CW-1:0] duty_in,
  input  logic [CH-1:0]    pol,
  input  logic             load,
  output logic [CH-1:0]    pwm_out,
  output logic             per_end,
  output logic             upd_pend
);

  localparam logic [CW-1:0] DEF_PER_W = CW'(DEF_PER);

  logic [CW-1:0] cnt_p0;
  logic [CW-1:0] per_act;
  logic [CW-1:0] per_sh;
  logic [CW-1:0] duty_act [CH];
  logic [CW-1:0] duty_sh  [CH];
  logic [CH-1:0] raw_p0;
  logic          wrap_p0;
  logic          apply_p0;

  // Stage 0: counter compare. While idle the shadow is copied to the active
  // registers every cycle, so idle behaves like a permanent wrap.
  assign wrap_p0  = en && (cnt_p0 == per_act);
  assign apply_p0 = !en || wrap_p0;

  always_comb begin
    raw_p0 = '0;
    for (int i = 0; i < CH; i++) begin
      raw_p0[i] = (cnt_p0 < duty_act[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (apply_p0) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + CW'(1);
    end
  end

  // A load on the apply cycle bypasses the shadow and never raises upd_pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_act  <= DEF_PER_W;
      per_sh   <= DEF_PER_W;
      upd_pend <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        duty_act[i] <= '0;
        duty_sh[i]  <= '0;
      end
    end else begin
      if (load) begin
        per_sh <= per_in;
        for (int i = 0; i < CH; i++) begin
          duty_sh[i] <= duty_in[i*CW +: CW];
        end
      end
      if (apply_p0) begin
        per_act  <= load ? per_in : per_sh;
        upd_pend <= 1'b0;
        for (int i = 0; i < CH; i++) begin
          duty_act[i] <= load ? duty_in[i*CW +: CW] : duty_sh[i];
        end
      end else if (load) begin
        upd_pend <= 1'b1;
      end
    end
  end

  // Stage 1: registered outputs; idle level is the inactive level per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
      per_end <= 1'b0;
    end else begin
      pwm_out <= en ? (raw_p0 ^ pol) : pol;
      per_end <= wrap_p0;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: directed scenarios plus a randomized run,
// each cycle checked against a period/phase reference model.
module tb_pwm_multi_ch;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int DEF_PER = 4999;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic [CW-1:0]    per_in = '0;
  logic [CH*CW-1:0] duty_in = '0;
  logic [CH-1:0]    pol = '0;
  logic             load = 1'b0;
  logic [CH-1:0]    pwm_out;
  logic             per_end;
  logic             upd_pend;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the current period plus active/pending settings.
  int m_phase;
  int m_per;
  int m_duty [CH];
  int m_sh_per;
  int m_sh_duty [CH];
  bit m_pend;

  pwm_multi_ch #(.CH(CH), .CW(CW), .DEF_PER(DEF_PER)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .per_in(per_in), .duty_in(duty_in),
    .pol(pol), .load(load), .pwm_out(pwm_out), .per_end(per_end), .upd_pend(upd_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_per = DEF_PER; m_sh_per = DEF_PER; m_pend = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0; m_sh_duty[i] = 0;
    end
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
    duty_in = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
  endtask

  // One clock: predict outputs from the period position, advance the model, compare.
  task automatic tick();
    logic [CH-1:0] ep;
    bit wrap, boundary;
    @(posedge clk);
    wrap = en && (m_phase == m_per);
    for (int i = 0; i < CH; i++)
      ep[i] = en ? ((m_phase < m_duty[i]) ^ pol[i]) : pol[i];
    boundary = !en || wrap;
    if (boundary) begin
      m_per = load ? int'(per_in) : m_sh_per;
      for (int i = 0; i < CH; i++)
        m_duty[i] = load ? int'(duty_in[i*CW +: CW]) : m_sh_duty[i];
      m_pend = 0;
    end
    if (load) begin
      m_sh_per = int'(per_in);
      for (int i = 0; i < CH; i++) m_sh_duty[i] = int'(duty_in[i*CW +: CW]);
      if (!boundary) m_pend = 1;
    end
    m_phase = boundary ? 0 : m_phase + 1;
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(ep));
    chk("per_end", 32'(per_end), 32'(wrap));
    chk("upd_pend", 32'(upd_pend), 32'(m_pend));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load();
    load = 1'b1; tick(); load = 1'b0;
  endtask

  task automatic wait_per_end(input int budget);
    for (int k = 0; k < budget && per_end !== 1'b1; k++) tick();
    chk("per_end_reached", 32'(per_end), 32'd1);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      hi += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    int hi, pe;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_per_end", 32'(per_end), 32'd0);
    chk("rst_upd_pend", 32'(upd_pend), 32'd0);
    #10 rst_n = 1'b1;
    ticks(2);

    // 1) defaults: 5000-cycle period, duty 0
    en = 1'b1;
    pe = 0;
    for (int k = 0; k < 10001; k++) begin
      tick();
      pe += int'(per_end);
    end
    chk("t1_per_end_count", 32'(pe), 32'd2);
    chk("t1_pwm_low", 32'(pwm_out), 32'd0);

    // 2) per=9, duty {0,3,10,255}
    per_in = 16'd9; set_duty(0, 3, 10, 255);
    do_load();
    chk("t2_pend", 32'(upd_pend), 32'd1);
    wait_per_end(6000);
    count_high(1, 10, hi);
    chk("t2_ch1_high", 32'(hi), 32'd3);
    chk("t2_per_end_again", 32'(per_end), 32'd1);
    count_high(2, 10, hi);
    chk("t2_ch2_high", 32'(hi), 32'd10);
    count_high(0, 10, hi);
    chk("t2_ch0_high", 32'(hi), 32'd0);

    // 3) duty 5 then 7 before the wrap; only 7 may appear
    ticks(3);
    set_duty(0, 5, 10, 255);
    do_load();
    chk("t3_pend", 32'(upd_pend), 32'd1);
    ticks(1);
    set_duty(0, 7, 10, 255);
    do_load();
    wait_per_end(20);
    chk("t3_pend_clr", 32'(upd_pend), 32'd0);
    count_high(1, 10, hi);
    chk("t3_ch1_high", 32'(hi), 32'd7);

    // 4) load on the wrap cycle itself
    for (int k = 0; k < 20 && m_phase != m_per; k++) tick();
    set_duty(0, 2, 10, 255);
    do_load();
    chk("t4_per_end", 32'(per_end), 32'd1);
    chk("t4_pend", 32'(upd_pend), 32'd0);
    count_high(1, 10, hi);
    chk("t4_ch1_high", 32'(hi), 32'd2);

    // 5) polarity and idle level
    pol = 4'b0010; en = 1'b0;
    ticks(2);
    chk("t5_idle", 32'(pwm_out), 32'b0010);
    en = 1'b1;
    count_high(1, 10, hi);
    chk("t5_ch1_inv_high", 32'(hi), 32'd8);
    pol = 4'b0000;
    ticks(3);

    // 6) per=0, duty=1 -> always active, per_end every cycle; then async reset
    per_in = 16'd0; set_duty(1, 1, 1, 1);
    do_load();
    wait_per_end(20);
    ticks(2);
    pe = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      pe += int'(per_end);
    end
    chk("t6_per_end_each", 32'(pe), 32'd5);
    chk("t6_pwm_on", 32'(pwm_out), 32'hF);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t6_rst_per_end", 32'(per_end), 32'd0);
    chk("t6_rst_pend", 32'(upd_pend), 32'd0);
    #3 rst_n = 1'b1;
    en = 1'b0;
    ticks(2);

    // Randomized: short periods, random duty/pol/load/en
    en = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        per_in = 16'($urandom_range(0, 12));
        set_duty($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      end
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 31) == 0) pol = 4'($urandom);
      tick();
    end
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
